jtdsp16_frac_cen: RTL

//  Fractional clock-enable generator. Produces cen at an average rate of n/m of clk for the

---
 rtl/jtdsp16_frac_cen.sv | 101 ++++++++++
 1 files changed

// File: rtl/jtdsp16_frac_cen.sv
// Fractional clock-enable generator: cen at an average rate of n/m of clk, plus a mid-period cenb.
// Optional cen pulse counter (cen_cnt) is built when JTDSP16_CEN_STATS_EN is defined.
module jtdsp16_frac_cen #(
  parameter int unsigned W = 10,
  parameter int unsigned N = 1,
  parameter int unsigned M = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] n_in,
  input  logic [W-1:0] m_in,
  input  logic         ld,
  input  logic         hold,
  output logic         cen,
  output logic         cenb,
  output logic         ld_ack,
`ifdef JTDSP16_CEN_STATS_EN
  output logic [15:0]  cen_cnt,
`endif
  output logic         bad_ratio
);

  logic [W-1:0] n, m, acc;
  logic [W-1:0] pend_n, pend_m;
  logic         pend, phase;
  logic [W:0]   sum, diff, half;
  logic         wrap, mid, ld_ok;

  // acc < m and n <= m, so W+1 bits hold the sum without wrap-around
  always_comb begin
    sum   = {1'b0, acc} + {1'b0, n};
    diff  = sum - {1'b0, m};
    half  = {1'b0, m >> 1};
    wrap  = sum >= {1'b0, m};
    mid   = phase && (sum >= half);
    ld_ok = ld && (n_in != '0) && (m_in != '0) && (n_in <= m_in);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n         <= W'(N);
      m         <= W'(M);
      acc       <= '0;
      phase     <= 1'b0;
      pend      <= 1'b0;
      pend_n    <= '0;
      pend_m    <= '0;
      cen       <= 1'b0;
      cenb      <= 1'b0;
      ld_ack    <= 1'b0;
      bad_ratio <= 1'b0;
    end else begin
      if (hold) begin
        cen    <= 1'b0;
        cenb   <= 1'b0;
        ld_ack <= 1'b0;
      end else if (wrap) begin
        cen   <= 1'b1;
        cenb  <= 1'b0;
        phase <= 1'b1;
        if (pend) begin
          // New ratio takes over on a cen boundary; the remainder is dropped
          n      <= pend_n;
          m      <= pend_m;
          acc    <= '0;
          ld_ack <= 1'b1;
          pend   <= 1'b0;
        end else begin
          acc    <= diff[W-1:0];
          ld_ack <= 1'b0;
        end
      end else begin
        acc    <= sum[W-1:0];
        cen    <= 1'b0;
        ld_ack <= 1'b0;
        cenb   <= mid;
        if (mid) phase <= 1'b0;
      end
      // A load on an application edge queues behind the ratio being applied
      if (ld_ok) begin
        pend      <= 1'b1;
        pend_n    <= n_in;
        pend_m    <= m_in;
        bad_ratio <= 1'b0;
      end else if (ld) begin
        bad_ratio <= 1'b1;
      end
    end
  end

`ifdef JTDSP16_CEN_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cen_cnt <= '0;
    end else if (!hold && wrap) begin
      cen_cnt <= pend ? 16'd0 : cen_cnt + 16'd1;
    end
  end
`endif

endmodule
